shift_out_param: RTL and testbench

Parametrised serializer that succeeds the fixed 24-bit multiplier result shifter. A rising edge on `sz` captures a `WIDTH`-bit parallel word and streams it one bit per clock on `z_out`. `fz` frames the valid bits, and a one-cycle `done` pulse marks the end of the frame. Bit order is selectable per frame. The block sits at the multiplier output and drives the serial result pin.

---
 rtl/shift_out_pkg.sv | 13 +
 rtl/edge_detect_rise.sv | 24 ++
 rtl/shift_out_param.sv | 147 ++++++++++++++
 tb/tb_shift_out_param.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/shift_out_pkg.sv
// Shared types and constants for the result serializer.
// Holds the FSM state encoding and the default word width.
package shift_out_pkg;

    localparam int SHIFT_OUT_DEFAULT_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector for a level request input.
// Ports: clk, reset (sync, active-low), d (level in), rise (d & ~d_prev).
// The history flop resets to 1 so a level held high through reset
// is not mistaken for a new request.
module edge_detect_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/shift_out_param.sv
// Parametrised serializer: a rising edge on sz captures z_parallel and
// streams it on z_out, framed by fz, followed by a one-cycle done pulse.
// Ports: clk, reset (sync, active-low), z_parallel[WIDTH], sz (start),
//        msb_first (bit order), z_out, fz, done, busy (all registered).
// Option: define SHIFT_OUT_PARITY_EN to append an even-parity bit.
module shift_out_param
    import shift_out_pkg::*;
#(
    parameter int WIDTH = SHIFT_OUT_DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] z_parallel,
    input  logic             sz,
    input  logic             msb_first,
    output logic             z_out,
    output logic             fz,
    output logic             done,
    output logic             busy
);

`ifdef SHIFT_OUT_PARITY_EN
    localparam int LEN = WIDTH + 1;
`else
    localparam int LEN = WIDTH;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic               msb_q, msb_d;
    logic               z_d, fz_d, done_d, busy_d;
    logic               start;
    logic               load;

`ifdef SHIFT_OUT_PARITY_EN
    localparam logic [CNT_W-1:0] PAR_AT = CNT_W'(WIDTH - 1);
    logic par_q, par_d;
`endif

    edge_detect_rise u_start (
        .clk   (clk),
        .reset (reset),
        .d     (sz),
        .rise  (start)
    );

    // A start is honoured only outside SHIFT; in DONE it chains a
    // new frame without passing through IDLE.
    assign load = start && (state_q != SHIFT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        msb_d   = msb_q;
        z_d     = 1'b0;
        fz_d    = 1'b0;
        done_d  = 1'b0;
`ifdef SHIFT_OUT_PARITY_EN
        par_d   = par_q;
`endif

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    // z_out already holds the current bit, so the
                    // register head is the one to present next.
                    cnt_d  = cnt_q + 1'b1;
                    fz_d   = 1'b1;
                    z_d    = msb_q ? sreg_q[WIDTH-1] : sreg_q[0];
                    sreg_d = msb_q ? (sreg_q << 1) : (sreg_q >> 1);
`ifdef SHIFT_OUT_PARITY_EN
                    if (cnt_q == PAR_AT) begin
                        z_d = par_q;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // First bit goes out straight from the input word; the
        // register keeps only what remains.
        if (load) begin
            state_d = SHIFT;
            cnt_d   = '0;
            msb_d   = msb_first;
            fz_d    = 1'b1;
            done_d  = 1'b0;
            z_d     = msb_first ? z_parallel[WIDTH-1] : z_parallel[0];
            sreg_d  = msb_first ? (z_parallel << 1) : (z_parallel >> 1);
`ifdef SHIFT_OUT_PARITY_EN
            par_d   = ^z_parallel;
`endif
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            msb_q   <= 1'b0;
            z_out   <= 1'b0;
            fz      <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            msb_q   <= msb_d;
            z_out   <= z_d;
            fz      <= fz_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end

`ifdef SHIFT_OUT_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_shift_out_param.sv
// Directed bench for shift_out_param with a bit-level scoreboard.
// Expected frame bits are queued at start and popped as fz runs.
module tb_shift_out_param;

    localparam int W = 24;
`ifdef SHIFT_OUT_PARITY_EN
    localparam int LEN = W + 1;
`else
    localparam int LEN = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] z_parallel;
    logic         sz;
    logic         msb_first;
    logic         z_out;
    logic         fz;
    logic         done;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic q[$];
    logic [LEN-1:0] cap;

    shift_out_param #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .z_parallel (z_parallel),
        .sz         (sz),
        .msb_first  (msb_first),
        .z_out      (z_out),
        .fz         (fz),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] w, input logic m);
        for (int i = 0; i < W; i++) begin
            q.push_back(m ? w[W-1-i] : w[i]);
        end
`ifdef SHIFT_OUT_PARITY_EN
        q.push_back(^w);
`endif
    endtask

    task automatic launch(input logic [W-1:0] w, input logic m);
        @(negedge clk);
        z_parallel = w;
        msb_first  = m;
        sz         = 1'b1;
        push_frame(w, m);
    endtask

    // Follow one frame already started at the previous edge.
    // keep_sz: leave sz high; rise_at: re-raise sz at that frame cycle;
    // chain: raise sz in the done cycle with (nw, nm).
    task automatic follow(input bit keep_sz, input int rise_at,
                          input bit chain, input logic [W-1:0] nw,
                          input logic nm, output logic [LEN-1:0] c);
        logic e;
        c = '0;
        for (int n = 1; n <= LEN; n++) begin
            @(negedge clk);
            if (q.size() > 0) e = q.pop_front();
            else e = 1'bx;
            chk("z_out", 32'(z_out), 32'(e));
            chk("fz_frame", 32'(fz), 32'd1);
            chk("busy_frame", 32'(busy), 32'd1);
            chk("done_frame", 32'(done), 32'd0);
            c[n-1] = z_out;
            if (n == 1 && !keep_sz) sz = 1'b0;
            if (n == rise_at) sz = 1'b1;
            z_parallel = W'($urandom);
            msb_first  = 1'($urandom);
        end
        @(negedge clk);
        chk("fz_end", 32'(fz), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        chk("z_out_end", 32'(z_out), 32'd0);
        chk("busy_done", 32'(busy), 32'd1);
        if (chain) begin
            z_parallel = nw;
            msb_first  = nm;
            sz         = 1'b1;
            push_frame(nw, nm);
        end else begin
            @(negedge clk);
            chk("done_clear", 32'(done), 32'd0);
            chk("busy_clear", 32'(busy), 32'd0);
            chk("fz_idle", 32'(fz), 32'd0);
        end
    endtask

    initial begin
        reset      = 1'b0;
        sz         = 1'b0;
        z_parallel = '0;
        msb_first  = 1'b0;

        @(negedge clk);
        chk("rst_z_out", 32'(z_out), 32'd0);
        chk("rst_fz", 32'(fz), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // LSB-first reference word
        launch(24'hA5C3F0, 1'b0);
        follow(1'b0, 0, 1'b0, '0, 1'b0, cap);
        chk("lsb_word", 32'(cap[W-1:0]), 32'h00A5C3F0);

        // MSB-first, chained back-to-back into a parity-1 word
        launch(24'hA5C3F0, 1'b1);
        follow(1'b0, 0, 1'b1, 24'h000007, 1'b0, cap);
        chk("msb_head", 32'(cap[7:0]), 32'h000000A5);
        chk("msb_tail", 32'(cap[W-1:W-4]), 32'd0);
        follow(1'b0, 0, 1'b0, '0, 1'b0, cap);
        chk("b2b_word", 32'(cap[W-1:0]), 32'h00000007);
`ifdef SHIFT_OUT_PARITY_EN
        chk("parity_bit", 32'(cap[LEN-1]), 32'd1);
`endif

        // sz held high for 60 cycles: one frame only
        launch(W'($urandom), 1'($urandom));
        follow(1'b1, 0, 1'b0, '0, 1'b0, cap);
        for (int i = 0; i < 60 - (LEN + 2); i++) begin
            @(negedge clk);
            chk("hold_no_fz", 32'(fz), 32'd0);
            chk("hold_no_busy", 32'(busy), 32'd0);
        end
        sz = 1'b0;

        // re-raise during SHIFT is ignored
        launch(24'h3C96E1, 1'b1);
        follow(1'b0, 10, 1'b0, '0, 1'b0, cap);
        @(negedge clk);
        chk("retrig_idle", 32'(busy), 32'd0);
        sz = 1'b0;

        // reset pulled at frame cycle 12
        launch(24'hFFFFFF, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            chk("pre_rst_fz", 32'(fz), 32'd1);
            chk("pre_rst_z", 32'(z_out), 32'(q.pop_front()));
        end
        reset = 1'b0;
        @(negedge clk);
        chk("abort_fz", 32'(fz), 32'd0);
        chk("abort_z_out", 32'(z_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_fz", 32'(fz), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_done", 32'(done), 32'd0);
        end
        sz = 1'b0;
        @(negedge clk);

        // normal operation after recovery
        launch(24'h800001, 1'b1);
        follow(1'b0, 0, 1'b0, '0, 1'b0, cap);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
